// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory request/ack, decode valid/ready and redirect inputs.
// master = fetch_ctrl side, slave = memory/decode/next-PC side.
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
      input  imem_ack, imem_rdata, inst_ready, redirect, redirect_target
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
      output imem_ack, imem_rdata, inst_ready, redirect, redirect_target
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, hands words to decode.
// Optional macro FETCH_DELAY_SLOT_EN selects branch-delay-slot redirects instead of squash.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned PC_STEP  = 4
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {st_idle, st_req, st_hold, st_halt} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;
   logic [31:0] ptgt_q, ptgt_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic        err_q, err_d;
   logic        misalign;
   logic [31:0] pc_seq;

   assign misalign = bus.redirect && (bus.redirect_target[1:0] != 2'b00);
   assign pc_seq   = pc_q + 32'(PC_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= st_idle;
         pc_q    <= RESET_PC;
         pend_q  <= 1'b0;
         ptgt_q  <= RESET_PC;
         inst_q  <= 32'h0;
         ipc_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         ptgt_q  <= ptgt_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      ptgt_d  = ptgt_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      err_d   = err_q;
      // A misaligned target is fatal from any live state; HALT ignores all inputs.
      if (state_q != st_halt && misalign) begin
         err_d   = 1'b1;
         state_d = st_halt;
      end else begin
         case (state_q)
            st_idle: begin
               state_d = st_req;
               if (bus.redirect) pc_d = bus.redirect_target;
            end
            st_req: begin
`ifdef FETCH_DELAY_SLOT_EN
               // In-flight word is the delay slot: keep it, remember the target.
               if (bus.redirect) begin
                  pend_d = 1'b1;
                  ptgt_d = bus.redirect_target;
               end
               if (bus.imem_ack) begin
                  inst_d  = bus.imem_rdata;
                  ipc_d   = pc_q;
                  state_d = st_hold;
               end
`else
               if (bus.imem_ack) begin
                  if (bus.redirect) begin
                     pc_d   = bus.redirect_target;
                     pend_d = 1'b0;
                  end else if (pend_q) begin
                     pc_d   = ptgt_q;
                     pend_d = 1'b0;
                  end else begin
                     inst_d  = bus.imem_rdata;
                     ipc_d   = pc_q;
                     state_d = st_hold;
                  end
               end else if (bus.redirect) begin
                  // Address must stay put until ack; apply the target afterwards.
                  pend_d = 1'b1;
                  ptgt_d = bus.redirect_target;
               end
`endif
            end
            st_hold: begin
`ifdef FETCH_DELAY_SLOT_EN
               if (bus.inst_ready) begin
                  state_d = st_req;
                  pend_d  = 1'b0;
                  if (bus.redirect)  pc_d = bus.redirect_target;
                  else if (pend_q)   pc_d = ptgt_q;
                  else               pc_d = pc_seq;
               end else if (bus.redirect) begin
                  pend_d = 1'b1;
                  ptgt_d = bus.redirect_target;
               end
`else
               if (bus.redirect) begin
                  pc_d    = bus.redirect_target;
                  state_d = st_req;
               end else if (bus.inst_ready) begin
                  pc_d    = pc_seq;
                  state_d = st_req;
               end
`endif
            end
            st_halt: ;
            default: state_d = st_idle;
         endcase
      end
   end

   assign bus.imem_req   = (state_q == st_req);
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = (state_q == st_hold);
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = ipc_q;
   assign bus.fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed literal scenarios, then randomized traffic
// compared every cycle against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] salt  = 32'h0;
   int          checks = 0;
   int          errors = 0;

   fetch_ctrl_if bus ();

   fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory returns the inverted address (optionally scrambled) whenever it acks.
   assign bus.imem_rdata = ~bus.imem_addr ^ salt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: "running" after the idle cycle, "have" = an instruction is held for decode,
   // otherwise a fetch of m_pc is outstanding. m_pend/m_ptgt = deferred redirect.
   logic        m_run, m_halt, m_err, m_have, m_pend;
   logic [31:0] m_pc, m_ptgt, m_inst, m_ipc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0; m_halt <= 1'b0; m_err <= 1'b0; m_have <= 1'b0; m_pend <= 1'b0;
         m_pc <= RST_PC; m_ptgt <= 32'h0; m_inst <= 32'h0; m_ipc <= 32'h0;
      end else if (!m_halt) begin
         if (bus.redirect && bus.redirect_target[1:0] != 2'b00) begin
            m_halt <= 1'b1;
            m_err  <= 1'b1;
            m_have <= 1'b0;
         end else if (!m_run) begin
            m_run <= 1'b1;
            if (bus.redirect) m_pc <= bus.redirect_target;
         end else if (m_have) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (bus.inst_ready) begin
               m_have <= 1'b0;
               m_pend <= 1'b0;
               m_pc   <= bus.redirect ? bus.redirect_target :
                         m_pend ? m_ptgt : m_pc + 32'd4;
            end else if (bus.redirect) begin
               m_pend <= 1'b1;
               m_ptgt <= bus.redirect_target;
            end
`else
            if (bus.redirect) begin
               m_have <= 1'b0;
               m_pc   <= bus.redirect_target;
            end else if (bus.inst_ready) begin
               m_have <= 1'b0;
               m_pc   <= m_pc + 32'd4;
            end
`endif
         end else begin
`ifdef FETCH_DELAY_SLOT_EN
            if (bus.redirect) begin
               m_pend <= 1'b1;
               m_ptgt <= bus.redirect_target;
            end
            if (bus.imem_ack) begin
               m_have <= 1'b1;
               m_inst <= ~m_pc ^ salt;
               m_ipc  <= m_pc;
            end
`else
            if (bus.imem_ack && bus.redirect) begin
               m_pc   <= bus.redirect_target;
               m_pend <= 1'b0;
            end else if (bus.imem_ack && m_pend) begin
               m_pc   <= m_ptgt;
               m_pend <= 1'b0;
            end else if (bus.imem_ack) begin
               m_have <= 1'b1;
               m_inst <= ~m_pc ^ salt;
               m_ipc  <= m_pc;
            end else if (bus.redirect) begin
               m_pend <= 1'b1;
               m_ptgt <= bus.redirect_target;
            end
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("m_imem_req", bus.imem_req, m_run && !m_halt && !m_have);
      chk("m_imem_addr", bus.imem_addr, m_pc);
      chk("m_inst_valid", bus.inst_valid, m_have && !m_halt);
      chk("m_inst", bus.inst, m_inst);
      chk("m_inst_pc", bus.inst_pc, m_ipc);
      chk("m_fetch_err", bus.fetch_err, m_err);
   end

   initial begin
      int hc;
      bus.imem_ack = 1'b1;
      bus.inst_ready = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_req", bus.imem_req, 1'b0);
      chk("rst_addr", bus.imem_addr, 32'h0000_3000);
      chk("rst_valid", bus.inst_valid, 1'b0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_err", bus.fetch_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("seq_req0", bus.imem_req, 1'b1);
      chk("seq_addr0", bus.imem_addr, 32'h0000_3000);
      @(negedge clk);
      chk("seq_valid0", bus.inst_valid, 1'b1);
      chk("seq_ipc0", bus.inst_pc, 32'h0000_3000);
      chk("seq_inst0", bus.inst, 32'hFFFF_CFFF);
      chk("seq_noreq", bus.imem_req, 1'b0);
      @(negedge clk);
      chk("seq_addr1", bus.imem_addr, 32'h0000_3004);
      bus.inst_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", bus.inst_valid, 1'b1);
         chk("stall_req", bus.imem_req, 1'b0);
         chk("stall_ipc", bus.inst_pc, 32'h0000_3004);
         chk("stall_inst", bus.inst, 32'hFFFF_CFFB);
         @(negedge clk);
      end
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("stall_next", bus.imem_addr, 32'h0000_3008);

      // Slow memory with a redirect in the first wait cycle.
      rst_n = 1'b0;
      bus.imem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_4000;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("wait_addr1", bus.imem_addr, 32'h0000_3000);
      @(negedge clk);
      chk("wait_addr2", bus.imem_addr, 32'h0000_3000);
      bus.imem_ack = 1'b1;
      @(negedge clk);
`ifdef FETCH_DELAY_SLOT_EN
      chk("ds_slot_ipc", bus.inst_pc, 32'h0000_3000);
      @(negedge clk);
      chk("ds_target", bus.imem_addr, 32'h0000_4000);
`else
      chk("drop_addr", bus.imem_addr, 32'h0000_4000);
      chk("drop_valid", bus.inst_valid, 1'b0);
      @(negedge clk);
      chk("drop_ipc", bus.inst_pc, 32'h0000_4000);
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_5000;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("sq_valid", bus.inst_valid, 1'b0);
      chk("sq_addr", bus.imem_addr, 32'h0000_5000);
      @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_target = 32'hFFFF_FFFC;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_ipc", bus.inst_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_zero", bus.imem_addr, 32'h0000_0000);
`endif
      bus.redirect = 1'b1;
      bus.redirect_target = 32'h0000_6002;
      @(negedge clk);
      bus.redirect_target = 32'h0000_7000;
      for (int i = 0; i < 3; i++) begin
         chk("halt_err", bus.fetch_err, 1'b1);
         chk("halt_req", bus.imem_req, 1'b0);
         chk("halt_valid", bus.inst_valid, 1'b0);
         @(negedge clk);
      end
      bus.redirect = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_err", bus.fetch_err, 1'b0);
      chk("arst_req", bus.imem_req, 1'b0);
      chk("arst_addr", bus.imem_addr, 32'h0000_3000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("resume_addr", bus.imem_addr, 32'h0000_3000);
      chk("resume_req", bus.imem_req, 1'b1);

      hc = 0;
      for (int i = 0; i < 3000; i++) begin
         int r;
         @(negedge clk);
         hc = m_halt ? hc + 1 : 0;
         if (hc > 3) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            hc = 0;
         end
         bus.imem_ack   = ($urandom_range(0, 9) < 7);
         bus.inst_ready = ($urandom_range(0, 9) < 7);
         bus.redirect   = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 49);
         if (r == 0)      bus.redirect_target = $urandom | 32'h1;
         else if (r < 5)  bus.redirect_target = 32'hFFFF_FFF8 | {29'h0, r[0], 2'b00};
         else             bus.redirect_target = $urandom & 32'hFFFF_FFFC;
         salt = $urandom;
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
